col_lifting_53: RTL

Parametrised vertical LeGall 5/3 lifting processor for the Wavelet-Transformer datapath. It is the generalised successor of the single-column, three-row processor. Each beat accepts one row-pair band (x[2k], x[2k+1], x[2k+2]) for LANES adjacent columns and produces the smooth (s) and detail (d) coefficients. It keeps the previous band's detail per column in an internal line buffer, applies symmetric extension at the top and bottom edges, and supports valid/ready backpressure.

---
 rtl/col_lifting_53.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/col_lifting_53.sv
// -----------------------------------------------------------------------------
// col_lifting_53
// Vertical LeGall 5/3 lifting over LANES adjacent columns per beat.
// Each accepted beat carries one band (x[2k], x[2k+1], x[2k+2]) and yields the
// smooth (s) and detail (d) coefficients two register stages later.
// The previous band's detail is kept per column group in a line buffer;
// top and bottom edges use symmetric extension.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   row_0/1/2         x[2k], x[2k+1], x[2k+2]; lane i at [i*DATA_W +: DATA_W]
//   out_valid/ready   output handshake
//   s                 signed smooth, DATA_W+2 bits per lane
//   d                 signed detail, DATA_W+1 bits per lane
//   out_col/out_band  column group / band tag of the output beat
//   out_last          final beat of the frame
//
// Build option
//   COL_LIFT_CLAMP_EN  when defined, s saturates to [0, 2^DATA_W-1]
// -----------------------------------------------------------------------------

// Per-lane datapath: detail predict in stage 1, smooth update in stage 2.
module col_lift53_lane #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ld1,
   input  logic              i_ld2,
   input  logic [DATA_W-1:0] i_x0,
   input  logic [DATA_W-1:0] i_x1,
   input  logic [DATA_W-1:0] i_x2,
   input  logic              i_first,
   input  logic              i_lastb,
   input  logic [DATA_W:0]   i_dp,
   output logic [DATA_W:0]   o_d_new,
   output logic [DATA_W+1:0] o_s,
   output logic [DATA_W:0]   o_d
);
   logic [DATA_W-1:0]        w_x2;
   logic [DATA_W:0]          w_sum, w_d, w_dp;
   logic [DATA_W-1:0]        r_x0;
   logic [DATA_W:0]          r_d, r_dp;
   logic signed [DATA_W+3:0] w_u, w_sh;
   logic [DATA_W+1:0]        w_s;
   logic [DATA_W+1:0]        r_s;
   logic [DATA_W:0]          r_dq;

   // Bottom edge mirrors x[2k+2] onto x[2k].
   assign w_x2    = i_lastb ? i_x0 : i_x2;
   assign w_sum   = {1'b0, i_x0} + {1'b0, w_x2};
   // |d| < 2^DATA_W, so modular DATA_W+1 arithmetic is exact.
   assign w_d     = {1'b0, i_x1} - (w_sum >> 1);
   // Top edge mirrors the missing previous detail onto the current one.
   assign w_dp    = i_first ? w_d : i_dp;
   assign o_d_new = w_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_x0 <= '0;
         r_d  <= '0;
         r_dp <= '0;
      end else if (i_ld1) begin
         r_x0 <= i_x0;
         r_d  <= w_d;
         r_dp <= w_dp;
      end
   end

   // floor((4*x0 + dp + d + 2) / 4) == x0 + floor((dp + d + 2) / 4)
   assign w_u  = {2'b00, r_x0, 2'b00} + {{3{r_d[DATA_W]}}, r_d}
               + {{3{r_dp[DATA_W]}}, r_dp} + (DATA_W+4)'(2);
   assign w_sh = w_u >>> 2;

`ifdef COL_LIFT_CLAMP_EN
   always_comb begin
      w_s = {2'b00, w_sh[DATA_W-1:0]};
      if (w_sh[DATA_W+3])
         w_s = '0;
      else if (|w_sh[DATA_W+2:DATA_W])
         w_s = {2'b00, {DATA_W{1'b1}}};
   end
`else
   assign w_s = (DATA_W+2)'(w_sh);
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s  <= '0;
         r_dq <= '0;
      end else if (i_ld2) begin
         r_s  <= w_s;
         r_dq <= r_d;
      end
   end

   assign o_s = r_s;
   assign o_d = r_dq;
endmodule

module col_lifting_53 #(
   parameter int DATA_W = 8,
   parameter int LANES  = 1,
   parameter int COLS   = 256,
   parameter int ROWS   = 256
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [LANES*DATA_W-1:0]          row_0,
   input  logic [LANES*DATA_W-1:0]          row_1,
   input  logic [LANES*DATA_W-1:0]          row_2,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES*(DATA_W+2)-1:0]      s,
   output logic [LANES*(DATA_W+1)-1:0]      d,
   output logic [$clog2(COLS/LANES)-1:0]    out_col,
   output logic [$clog2(ROWS/2)-1:0]        out_band,
   output logic                             out_last
);
   localparam int NG = COLS / LANES;
   localparam int NB = ROWS / 2;
   localparam int CW = $clog2(NG);
   localparam int BW = $clog2(NB);
   localparam int DW = DATA_W + 1;
   localparam int SW = DATA_W + 2;

   logic                  w_adv, w_acc, w_ld2;
   logic                  w_first, w_lastb, w_lastc;
   logic [CW-1:0]         r_c, r_col1;
   logic [BW-1:0]         r_k, r_band1;
   logic                  r_v1, r_last1;
   logic [LANES*DW-1:0]   r_lb [NG];
   logic [LANES*DW-1:0]   w_dp_rd, w_d_new;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;
   assign w_acc    = in_valid && w_adv;
   assign w_ld2    = w_adv && r_v1;
   assign w_first  = (r_k == '0);
   assign w_lastb  = (r_k == BW'(NB - 1));
   assign w_lastc  = (r_c == CW'(NG - 1));

   // Input position counters: column group fastest, then band.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c <= '0;
         r_k <= '0;
      end else if (w_acc) begin
         if (w_lastc) begin
            r_c <= '0;
            r_k <= w_lastb ? '0 : r_k + BW'(1);
         end else begin
            r_c <= r_c + CW'(1);
         end
      end
   end

   // Line buffer of previous-band details; contents after reset are never
   // consumed because band 0 uses the top mirror.
   assign w_dp_rd = r_lb[r_c];
   always_ff @(posedge clk) begin
      if (w_acc && !reset)
         r_lb[r_c] <= w_d_new;
   end

   // Stage 1 tags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1    <= 1'b0;
         r_col1  <= '0;
         r_band1 <= '0;
         r_last1 <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= w_acc;
         if (w_acc) begin
            r_col1  <= r_c;
            r_band1 <= r_k;
            r_last1 <= w_lastc && w_lastb;
         end
      end
   end

   // Stage 2 tags; held when the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_col   <= '0;
         out_band  <= '0;
         out_last  <= 1'b0;
      end else if (w_adv) begin
         out_valid <= r_v1;
         if (r_v1) begin
            out_col  <= r_col1;
            out_band <= r_band1;
            out_last <= r_last1;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      col_lift53_lane #(.DATA_W(DATA_W)) u_lane (
         .i_clk   (clk),
         .i_reset (reset),
         .i_ld1   (w_acc),
         .i_ld2   (w_ld2),
         .i_x0    (row_0[g*DATA_W +: DATA_W]),
         .i_x1    (row_1[g*DATA_W +: DATA_W]),
         .i_x2    (row_2[g*DATA_W +: DATA_W]),
         .i_first (w_first),
         .i_lastb (w_lastb),
         .i_dp    (w_dp_rd[g*DW +: DW]),
         .o_d_new (w_d_new[g*DW +: DW]),
         .o_s     (s[g*SW +: SW]),
         .o_d     (d[g*DW +: DW])
      );
   end
endmodule
